// File: rtl/param_fifo_pkg.sv
// Shared defaults and width helpers for param_fifo and its instantiators.
package param_fifo_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_AE_LEVEL = 2;

    // Accepted-operation classification for one edge, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge ck) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FWFT FIFO with occupancy count, threshold flags
// and one-cycle overflow/underflow pulses.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          insert,
    input  logic                          remove,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned CW = count_width(DEPTH);
    localparam int unsigned AW = CW - 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] rdata;
    logic             wr_ok;
    logic             rd_ok;
    fifo_op_e         op;

    // A full FIFO still takes a write when the same edge pops the head.
    assign wr_ok = insert && (!full || remove);
    assign rd_ok = remove && !empty;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_comb begin
        count_next = count;
        case (op)
            OP_PUSH: count_next = count + CW'(1);
            OP_POP:  count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_next;
            overflow  <= insert && !wr_ok;
            underflow <= remove && !rd_ok;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .ck    (ck),
        .we    (wr_ok && !reset && !flush),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign data_out     = empty ? '0 : rdata;

endmodule
